// File: rtl/pkt_buffer_reader_if.sv
// Signal bundle between the packet buffer read engine and its neighbours:
// scheduler descriptors, address manager controls, data buffer port and egress stream.
interface pkt_buffer_reader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 12
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  s_axis_desc_valid;
    logic                  s_axis_desc_ready;
    logic [ADDR_WIDTH-1:0] s_axis_desc_sop_addr;
    logic [LEN_WIDTH-1:0]  s_axis_desc_len;
    logic [KEEP_WIDTH-1:0] s_axis_desc_last_keep;
    logic                  m_axis_rd_first_word_en;
    logic [ADDR_WIDTH-1:0] m_axis_rd_pkt_sop_addr;
    logic                  m_axis_rd_en;
    logic [ADDR_WIDTH-1:0] s_axis_fl_tail;
    logic                  m_axis_buf_rd_en;
    logic [ADDR_WIDTH-1:0] m_axis_buf_rd_addr;
    logic [DATA_WIDTH-1:0] s_axis_buf_rd_data;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_busy;

    modport master (
        input  s_axis_desc_valid, s_axis_desc_sop_addr, s_axis_desc_len, s_axis_desc_last_keep,
        input  s_axis_fl_tail, s_axis_buf_rd_data, m_axis_tready,
        output s_axis_desc_ready, m_axis_rd_first_word_en, m_axis_rd_pkt_sop_addr, m_axis_rd_en,
        output m_axis_buf_rd_en, m_axis_buf_rd_addr, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        output m_axis_tvalid, m_axis_busy
    );

    modport slave (
        output s_axis_desc_valid, s_axis_desc_sop_addr, s_axis_desc_len, s_axis_desc_last_keep,
        output s_axis_fl_tail, s_axis_buf_rd_data, m_axis_tready,
        input  s_axis_desc_ready, m_axis_rd_first_word_en, m_axis_rd_pkt_sop_addr, m_axis_rd_en,
        input  m_axis_buf_rd_en, m_axis_buf_rd_addr, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        input  m_axis_tvalid, m_axis_busy
    );
endinterface

// File: rtl/pkt_buffer_reader.sv
// Packet buffer read engine: takes a descriptor, walks the word chain via the address
// manager's fl_tail, and streams the words out through a small skid FIFO.
module pkt_buffer_reader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 256,
    parameter int LEN_WIDTH      = 12,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rstn,
    pkt_buffer_reader_if.master bus
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int PW = $clog2(OUT_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LINK = 2'd1,
        READ = 2'd2
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] sop_r;
    logic [LEN_WIDTH-1:0]  len_m1_r;
    logic [LEN_WIDTH-1:0]  cnt_r;
    logic [KW-1:0]         keep_r;
    logic                  desc_ready_r;
    logic                  first_word_en_r;

    logic                  inflight_r;
    logic                  inflight_last_r;
    logic [KW-1:0]         inflight_keep_r;

    logic [DATA_WIDTH-1:0] data_mem_r [OUT_FIFO_DEPTH];
    logic [KW-1:0]         keep_mem_r [OUT_FIFO_DEPTH];
    logic                  last_mem_r [OUT_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;

    logic                  pop_s;
    logic                  issue_s;
    logic                  last_issue_s;
    logic [OW-1:0]         occ_s;

    // Issue decision: count the in-flight read as occupied so the FIFO can never overflow.
    always_comb begin
        pop_s        = 1'b0;
        occ_s        = {OW{1'b0}};
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        pop_s        = (count_r != {CW{1'b0}}) && bus.m_axis_tready;
        occ_s        = OW'(count_r) + OW'(inflight_r);
        if ((state_r == READ) && ((occ_s - OW'(pop_s)) < OW'(OUT_FIFO_DEPTH))) begin
            issue_s      = 1'b1;
            last_issue_s = (cnt_r == len_m1_r);
        end else begin
            issue_s      = 1'b0;
            last_issue_s = 1'b0;
        end
    end

    // Descriptor FSM with registered handshake and link outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r         <= IDLE;
            sop_r           <= {ADDR_WIDTH{1'b0}};
            len_m1_r        <= {LEN_WIDTH{1'b0}};
            cnt_r           <= {LEN_WIDTH{1'b0}};
            keep_r          <= {KW{1'b0}};
            desc_ready_r    <= 1'b0;
            first_word_en_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.s_axis_desc_valid && desc_ready_r) begin
                        sop_r           <= bus.s_axis_desc_sop_addr;
                        // A zero length still carries one word.
                        len_m1_r        <= (bus.s_axis_desc_len == {LEN_WIDTH{1'b0}}) ?
                                           {LEN_WIDTH{1'b0}} : (bus.s_axis_desc_len - LEN_WIDTH'(1));
                        keep_r          <= bus.s_axis_desc_last_keep;
                        cnt_r           <= {LEN_WIDTH{1'b0}};
                        desc_ready_r    <= 1'b0;
                        first_word_en_r <= 1'b1;
                        state_r         <= LINK;
                    end else begin
                        desc_ready_r    <= 1'b1;
                        first_word_en_r <= 1'b0;
                    end
                end
                LINK: begin
                    first_word_en_r <= 1'b0;
                    state_r         <= READ;
                end
                READ: begin
                    if (issue_s) begin
                        cnt_r <= cnt_r + LEN_WIDTH'(1);
                        if (last_issue_s) begin
                            state_r      <= IDLE;
                            desc_ready_r <= 1'b1;
                        end else begin
                            state_r      <= READ;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    desc_ready_r    <= 1'b0;
                    first_word_en_r <= 1'b0;
                end
            endcase
        end
    end

    // In-flight tag: buffer data returns one cycle after issue, tagged with its position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            inflight_keep_r <= {KW{1'b0}};
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
            inflight_keep_r <= last_issue_s ? keep_r : {KW{1'b1}};
        end
    end

    // Output skid FIFO: written from the in-flight read, drained by the egress handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
                data_mem_r[i] <= {DATA_WIDTH{1'b0}};
                keep_mem_r[i] <= {KW{1'b0}};
                last_mem_r[i] <= 1'b0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (inflight_r) begin
                data_mem_r[wr_ptr_r] <= bus.s_axis_buf_rd_data;
                keep_mem_r[wr_ptr_r] <= inflight_keep_r;
                last_mem_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + CW'(inflight_r) - CW'(pop_s);
        end
    end

    assign bus.s_axis_desc_ready       = desc_ready_r;
    assign bus.m_axis_rd_first_word_en = first_word_en_r;
    assign bus.m_axis_rd_pkt_sop_addr  = sop_r;
    // fl_tail advances on each rd_en, so the read address must follow it combinationally.
    assign bus.m_axis_rd_en            = issue_s;
    assign bus.m_axis_buf_rd_en        = issue_s;
    assign bus.m_axis_buf_rd_addr      = issue_s ? bus.s_axis_fl_tail : {ADDR_WIDTH{1'b0}};
    assign bus.m_axis_tdata            = data_mem_r[rd_ptr_r];
    assign bus.m_axis_tkeep            = keep_mem_r[rd_ptr_r];
    assign bus.m_axis_tlast            = last_mem_r[rd_ptr_r];
    assign bus.m_axis_tvalid           = (count_r != {CW{1'b0}});
    assign bus.m_axis_busy             = (state_r != IDLE) || (count_r != {CW{1'b0}}) || inflight_r;
endmodule

// File: tb/tb_pkt_buffer_reader.sv
// Self-checking bench for pkt_buffer_reader: address manager / buffer model, scoreboard of
// expected stream words, and cycle-level checks of link/read/stream timing.
module tb_pkt_buffer_reader;
    localparam int AW    = 12;
    localparam int DW    = 256;
    localparam int LW    = 12;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [AW-1:0] link_tbl [0:4095];
    logic [31:0]   salt;
    exp_t          sb [$];
    int            fwe_cyc [$];
    logic [AW-1:0] fwe_addr [$];
    int            rd_cyc [$];
    logic [AW-1:0] rd_addr [$];
    int            tv_cyc [$];
    logic          tlast_q [$];
    int            acc_cyc;

    logic          hold_r = 1'b0;
    logic [DW-1:0] hold_d;
    logic [KW-1:0] hold_k;
    logic          hold_l;

    always #5 clk = ~clk;

    pkt_buffer_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    pkt_buffer_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .OUT_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {8{{a, 20'h5A5A5} ^ salt}};
    endfunction

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // address manager and data buffer model
    always @(posedge clk) begin
        if (!rstn) begin
            bus.s_axis_fl_tail     <= '0;
            bus.s_axis_buf_rd_data <= '0;
        end else begin
            if (bus.m_axis_rd_first_word_en)
                bus.s_axis_fl_tail <= bus.m_axis_rd_pkt_sop_addr;
            else if (bus.m_axis_rd_en)
                bus.s_axis_fl_tail <= link_tbl[bus.s_axis_fl_tail];
            if (bus.m_axis_buf_rd_en)
                bus.s_axis_buf_rd_data <= word_of(bus.m_axis_buf_rd_addr);
        end
    end

    // output monitor and scoreboard comparison
    always @(negedge clk) begin
        if (rstn) begin
            check_eq("fwe_rd_excl", bus.m_axis_rd_first_word_en & bus.m_axis_rd_en, 0);
            if (bus.m_axis_rd_first_word_en) begin
                fwe_cyc.push_back(cyc);
                fwe_addr.push_back(bus.m_axis_rd_pkt_sop_addr);
            end
            if (bus.m_axis_rd_en) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(bus.m_axis_buf_rd_addr);
                check_eq("buf_rd_en", bus.m_axis_buf_rd_en, 1);
            end
            if (hold_r) begin
                check_eq("hold_tdata", bus.m_axis_tdata, hold_d);
                check_eq("hold_tkeep", bus.m_axis_tkeep, hold_k);
                check_eq("hold_tlast", bus.m_axis_tlast, hold_l);
                check_eq("hold_tvalid", bus.m_axis_tvalid, 1);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("tdata", bus.m_axis_tdata, e.d);
                    check_eq("tkeep", bus.m_axis_tkeep, e.k);
                    check_eq("tlast", bus.m_axis_tlast, e.l);
                end
                tv_cyc.push_back(cyc);
                tlast_q.push_back(bus.m_axis_tlast);
            end
            hold_r <= bus.m_axis_tvalid && !bus.m_axis_tready;
            hold_d <= bus.m_axis_tdata;
            hold_k <= bus.m_axis_tkeep;
            hold_l <= bus.m_axis_tlast;
        end else begin
            hold_r <= 1'b0;
        end
    end

    task automatic clear_logs();
        fwe_cyc.delete(); fwe_addr.delete(); rd_cyc.delete(); rd_addr.delete();
        tv_cyc.delete(); tlast_q.delete();
    endtask

    task automatic send_desc(input logic [AW-1:0] sop, input logic [LW-1:0] len,
                             input logic [KW-1:0] keep, input bit hold);
        logic [AW-1:0] a;
        int            n;
        bit            got;
        exp_t          e;
        a = sop;
        n = (len == 0) ? 1 : int'(len);
        for (int i = 0; i < n; i++) begin
            e.d = word_of(a);
            e.l = (i == n - 1);
            e.k = e.l ? keep : '1;
            sb.push_back(e);
            a = link_tbl[a];
        end
        bus.s_axis_desc_valid     = 1'b1;
        bus.s_axis_desc_sop_addr  = sop;
        bus.s_axis_desc_len       = len;
        bus.s_axis_desc_last_keep = keep;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.s_axis_desc_ready;
        end
        check_eq("desc_accept", got, 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        if (!hold) bus.s_axis_desc_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !bus.m_axis_busy;
        end
        check_eq("drain_sb", sb.size(), 0);
        check_eq("drain_busy", bus.m_axis_busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, bus.s_axis_desc_ready, 0);
        check_eq({tag, "_fwe"}, bus.m_axis_rd_first_word_en, 0);
        check_eq({tag, "_rd_en"}, bus.m_axis_rd_en, 0);
        check_eq({tag, "_buf_rd_en"}, bus.m_axis_buf_rd_en, 0);
        check_eq({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        check_eq({tag, "_tdata"}, bus.m_axis_tdata, 0);
        check_eq({tag, "_tlast"}, bus.m_axis_tlast, 0);
        check_eq({tag, "_busy"}, bus.m_axis_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) link_tbl[i] = AW'(i + 1);
        salt                      = 32'h1111_0000;
        rstn                      = 1'b0;
        bus.s_axis_desc_valid     = 1'b0;
        bus.s_axis_desc_sop_addr  = '0;
        bus.s_axis_desc_len       = '0;
        bus.s_axis_desc_last_keep = '0;
        bus.m_axis_tready         = 1'b0;

        // reset state and release
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rel_ready", bus.s_axis_desc_ready, 1);
        check_eq("rel_tvalid", bus.m_axis_tvalid, 0);

        // single packet along a non-contiguous chain
        @(posedge clk); #1;
        link_tbl[12'h005] = 12'h009;
        link_tbl[12'h009] = 12'h00A;
        bus.m_axis_tready = 1'b1;
        clear_logs();
        send_desc(12'h005, 12'd3, 32'h0000_FFFF, 1'b0);
        wait_drain();
        check_eq("t2_fwe_n", fwe_cyc.size(), 1);
        check_eq("t2_rd_n", rd_cyc.size(), 3);
        check_eq("t2_tv_n", tv_cyc.size(), 3);
        if (fwe_cyc.size() == 1) begin
            check_eq("t2_fwe_cyc", fwe_cyc[0], acc_cyc + 1);
            check_eq("t2_fwe_addr", fwe_addr[0], 12'h005);
        end
        if (rd_cyc.size() == 3) begin
            check_eq("t2_rd_cyc0", rd_cyc[0], acc_cyc + 2);
            check_eq("t2_rd_cyc2", rd_cyc[2], acc_cyc + 4);
            check_eq("t2_rd_addr0", rd_addr[0], 12'h005);
            check_eq("t2_rd_addr1", rd_addr[1], 12'h009);
            check_eq("t2_rd_addr2", rd_addr[2], 12'h00A);
        end
        if (tv_cyc.size() == 3) begin
            check_eq("t2_tv_cyc0", tv_cyc[0], acc_cyc + 4);
            check_eq("t2_tv_cyc2", tv_cyc[2], acc_cyc + 6);
        end

        // backpressure: FIFO fills to depth, then everything drains in order
        @(posedge clk); #1;
        salt = 32'h2222_0000;
        bus.m_axis_tready = 1'b0;
        clear_logs();
        send_desc(12'h020, 12'd8, 32'h0000_00FF, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("t3_stall_rd_n", rd_cyc.size(), DEPTH);
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        wait_drain();
        check_eq("t3_rd_n", rd_cyc.size(), 8);
        check_eq("t3_tv_n", tv_cyc.size(), 8);

        // back-to-back descriptors with valid held
        @(posedge clk); #1;
        salt = 32'h3333_0000;
        clear_logs();
        send_desc(12'h030, 12'd1, 32'h0000_000F, 1'b1);
        send_desc(12'h040, 12'd2, 32'h0000_0003, 1'b0);
        wait_drain();
        check_eq("t4_fwe_n", fwe_cyc.size(), 2);
        check_eq("t4_rd_n", rd_cyc.size(), 3);
        if (fwe_cyc.size() == 2 && rd_cyc.size() == 3)
            check_eq("t4_fwe_gap", fwe_cyc[1], rd_cyc[0] + 2);
        if (tlast_q.size() == 3) begin
            check_eq("t4_tlast0", tlast_q[0], 1);
            check_eq("t4_tlast1", tlast_q[1], 0);
            check_eq("t4_tlast2", tlast_q[2], 1);
        end

        // asynchronous reset in the middle of a packet
        @(posedge clk); #1;
        salt = 32'h4444_0000;
        clear_logs();
        send_desc(12'h050, 12'd6, 32'h0000_0F0F, 1'b0);
        for (int i = 0; i < 50 && rd_cyc.size() < 3; i++) @(negedge clk);
        check_eq("t5_pre_rd_n", rd_cyc.size(), 3);
        #1;
        rstn = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_rel_ready", bus.s_axis_desc_ready, 1);
        check_eq("t5_rel_tvalid", bus.m_axis_tvalid, 0);
        @(posedge clk); #1;
        clear_logs();
        send_desc(12'h100, 12'd1, 32'hF000_0000, 1'b0);
        wait_drain();
        check_eq("t5_rd_n", rd_cyc.size(), 1);
        if (rd_addr.size() == 1) check_eq("t5_rd_addr", rd_addr[0], 12'h100);

        // address wrap and zero length
        @(posedge clk); #1;
        salt = 32'h5555_0000;
        link_tbl[12'hFFF] = 12'h000;
        clear_logs();
        send_desc(12'hFFF, 12'd2, 32'h00FF_00FF, 1'b0);
        wait_drain();
        check_eq("t6_rd_n", rd_cyc.size(), 2);
        if (rd_addr.size() == 2) begin
            check_eq("t6_rd_addr0", rd_addr[0], 12'hFFF);
            check_eq("t6_rd_addr1", rd_addr[1], 12'h000);
        end
        @(posedge clk); #1;
        clear_logs();
        send_desc(12'h200, 12'd0, 32'h0000_0001, 1'b0);
        wait_drain();
        check_eq("t6_len0_rd_n", rd_cyc.size(), 1);
        check_eq("t6_len0_tv_n", tv_cyc.size(), 1);
        if (tlast_q.size() == 1) check_eq("t6_len0_tlast", tlast_q[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
